// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: one write beat or an incrementing read burst
// of up to 256 beats per command, each beat answered on a valid/ready response port.
module wb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    input  logic [7:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_e;

    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  sync_q;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] wdog_q, wdog_d;
    logic        accept;
    logic        last;
    logic        timeout;

    // Reset asserts asynchronously everywhere; release is only trusted once it
    // has passed through two flops, so the first accept waits for sync_q[1].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign accept  = (state_q == IDLE) && cmd_valid && sync_q[1];
    assign last    = (cnt_q == 8'd0) || err_q;
    assign timeout = (wdog_q == WDOG_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACK is checked before the watchdog so a last-moment acknowledge still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (wb_ack_i || timeout) state_d = RSP;
            RSP:     if (rsp_ready) state_d = last ? IDLE : BUS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        wb_cyc_o  = (state_q == BUS);
        wb_stb_o  = (state_q == BUS);
        rsp_valid = (state_q == RSP);
        rsp_last  = (state_q == RSP) && last;
    end

    always_comb begin
        adr_d  = adr_q;
        dat_d  = dat_q;
        sel_d  = sel_q;
        we_d   = we_q;
        cnt_d  = cnt_q;
        rdat_d = rdat_q;
        err_d  = err_q;
        wdog_d = 16'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    adr_d  = cmd_adr & 32'hFFFF_FFFC;
                    dat_d  = cmd_dat;
                    sel_d  = cmd_sel;
                    we_d   = cmd_we;
                    cnt_d  = cmd_we ? 8'd0 : cmd_len;
                    rdat_d = 32'd0;
                    err_d  = 1'b0;
                end
            end
            BUS: begin
                wdog_d = wdog_q + 16'd1;
                if (wb_ack_i) begin
                    rdat_d = we_q ? 32'd0 : wb_dat_i;
                    err_d  = 1'b0;
                end else if (timeout) begin
                    rdat_d = 32'd0;
                    err_d  = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready && !last) begin
                    cnt_d = cnt_q - 8'd1;
                    adr_d = adr_q + 32'd4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adr_q  <= 32'd0;
            dat_q  <= 32'd0;
            sel_q  <= 4'd0;
            we_q   <= 1'b0;
            cnt_q  <= 8'd0;
            rdat_q <= 32'd0;
            err_q  <= 1'b0;
            wdog_q <= 16'd0;
        end else begin
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            sel_q  <= sel_d;
            we_q   <= we_d;
            cnt_q  <= cnt_d;
            rdat_q <= rdat_d;
            err_q  <= err_d;
            wdog_q <= wdog_d;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign rsp_dat  = rdat_q;
    assign rsp_err  = err_q;

endmodule
